bfloat16_fma: RTL and testbench

Single-precision-reduced fused multiply-add for the bfloat16 accelerator datapath: computes round(a × b + c) with one final rounding. It sits in the accelerator's compute lane between operand fetch and result writeback. Inputs are sampled every cycle a valid strobe is present, and results appear registered one cycle later.

---
 rtl/bf16_pkg.sv | 25 ++
 rtl/bf16_lzc.sv | 21 ++
 rtl/bfloat16_fma.sv | 178 +++++++++++++++++
 tb/tb_bfloat16_fma.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf16_pkg.sv
// bfloat16 field layout, datapath widths and special encodings shared by the FMA.
package bf16_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 7;
  localparam int BIAS    = 127;

  localparam int SIG_W   = FRAC_W + 1;       // significand including hidden bit
  localparam int PROD_W  = 2 * SIG_W;        // exact 2.14 product
  localparam int GUARD_W = 12;               // extra low bits kept during alignment
  localparam int ALIGN_W = PROD_W + GUARD_W; // 28-bit alignment datapath
  localparam int SUM_W   = ALIGN_W + 1;      // one carry bit for effective addition
  localparam int LZC_W   = 5;

  localparam logic [15:0] QNAN    = 16'h7FC0;
  localparam logic [15:0] POS_INF = 16'h7F80;
  localparam logic [15:0] NEG_INF = 16'hFF80;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } bf16_t;

endpackage

// File: rtl/bf16_lzc.sv
// Leading-zero counter over the normalization-width sum; an all-zero input reports W.
module bf16_lzc #(
  parameter int W  = 29,
  parameter int CW = 5
) (
  input  logic [W-1:0]  din,
  output logic [CW-1:0] count,
  output logic          all_zero
);

  // Scanning upward lets the highest set bit win the last assignment.
  always_comb begin
    count = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (din[i]) count = CW'(W - 1 - i);
    end
  end

  assign all_zero = ~|din;

endmodule

// File: rtl/bfloat16_fma.sv
// bfloat16 fused multiply-add: round(a*b + c) with a single RNE rounding,
// flush-to-zero on inputs and outputs, one registered output stage.
module bfloat16_fma
  import bf16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  output logic        out_valid,
  output logic [15:0] result
);

  localparam logic signed [9:0] EXP_BIAS  = $signed(10'(BIAS));
  localparam logic signed [9:0] ALIGN_SAT = $signed(10'(ALIGN_W));
  localparam logic signed [9:0] EXP_MAX   = 10'sd255;

  bf16_t      op [3];
  logic [2:0] op_zero;
  logic [2:0] op_inf;
  logic [2:0] op_nan;

  assign op[0] = a;
  assign op[1] = b;
  assign op[2] = c;

  for (genvar gi = 0; gi < 3; gi++) begin : g_decode
    assign op_zero[gi] = (op[gi].exp == '0);
    assign op_inf[gi]  = (op[gi].exp == '1) && (op[gi].frac == '0);
    assign op_nan[gi]  = (op[gi].exp == '1) && (op[gi].frac != '0);
  end

  logic prod_sign;
  logic prod_zero;
  logic prod_inf;
  logic zero_inf;
  logic c_zero;
  logic c_inf;
  logic any_nan;

  assign prod_sign = op[0].sign ^ op[1].sign;
  assign prod_zero = op_zero[0] | op_zero[1];
  assign prod_inf  = op_inf[0] | op_inf[1];
  assign zero_inf  = (op_inf[0] & op_zero[1]) | (op_inf[1] & op_zero[0]);
  assign c_zero    = op_zero[2];
  assign c_inf     = op_inf[2];
  assign any_nan   = |op_nan;

  logic        special;
  logic [15:0] special_val;

  always_comb begin
    special     = 1'b1;
    special_val = QNAN;
    if (any_nan || zero_inf) begin
      special_val = QNAN;
    end else if (prod_inf && c_inf && (prod_sign != op[2].sign)) begin
      special_val = QNAN;
    end else if (prod_inf) begin
      special_val = prod_sign ? NEG_INF : POS_INF;
    end else if (c_inf) begin
      special_val = c;
    end else if (prod_zero) begin
      // A zero sum is -0 only when both contributions are negative zeros.
      special_val = c_zero ? {prod_sign & op[2].sign, 15'b0} : c;
    end else begin
      special = 1'b0;
    end
  end

  // Multiply, align and add. Both operands live in a 2.14 frame placed at the
  // top of the alignment datapath, so bit 26 is the units place of big_exp.
  logic [SIG_W-1:0]   ma, mb, mc;
  logic [PROD_W-1:0]  prod_sig;
  logic signed [9:0]  prod_exp, c_exp, big_exp, exp_diff;
  logic               prod_big;
  logic [4:0]         shamt;
  logic [ALIGN_W-1:0] prod_op, c_op, x_op, y_op, y_shift, y_mask, y_al;
  logic               x_sign, y_sign, eff_sub, sticky;
  logic [SUM_W:0]     raw;
  logic               res_neg, res_sign;
  logic [SUM_W-1:0]   mag;

  always_comb begin
    ma       = {1'b1, op[0].frac};
    mb       = {1'b1, op[1].frac};
    mc       = {1'b1, op[2].frac};
    prod_sig = PROD_W'(ma) * PROD_W'(mb);
    prod_exp = $signed({2'b00, op[0].exp}) + $signed({2'b00, op[1].exp}) - EXP_BIAS;
    c_exp    = $signed({2'b00, op[2].exp});

    // A zero addend contributes nothing, so the product always leads then.
    prod_big = c_zero || (prod_exp >= c_exp);
    exp_diff = prod_big ? (prod_exp - c_exp) : (c_exp - prod_exp);
    big_exp  = prod_big ? prod_exp : c_exp;
    shamt    = (exp_diff >= ALIGN_SAT) ? 5'(ALIGN_W) : exp_diff[4:0];

    prod_op  = {prod_sig, {GUARD_W{1'b0}}};
    c_op     = c_zero ? '0 : {1'b0, mc, {(ALIGN_W - SIG_W - 1){1'b0}}};
    x_op     = prod_big ? prod_op : c_op;
    y_op     = prod_big ? c_op : prod_op;
    x_sign   = prod_big ? prod_sign : op[2].sign;
    y_sign   = prod_big ? op[2].sign : prod_sign;

    y_shift  = y_op >> shamt;
    y_mask   = ~({ALIGN_W{1'b1}} << shamt);
    sticky   = |(y_op & y_mask);
    y_al     = y_shift | {{(ALIGN_W - 1){1'b0}}, sticky};

    eff_sub  = prod_sign ^ op[2].sign;
    raw      = eff_sub ? ({2'b00, x_op} - {2'b00, y_al})
                       : ({2'b00, x_op} + {2'b00, y_al});
    res_neg  = raw[SUM_W];
    mag      = res_neg ? (~raw[SUM_W-1:0] + SUM_W'(1)) : raw[SUM_W-1:0];
    res_sign = res_neg ? y_sign : x_sign;
  end

  logic [LZC_W-1:0] lz;
  logic             mag_zero;

  bf16_lzc #(
    .W  (SUM_W),
    .CW (LZC_W)
  ) u_lzc (
    .din      (mag),
    .count    (lz),
    .all_zero (mag_zero)
  );

  logic [SUM_W-1:0]  norm;
  logic [SIG_W-1:0]  mant;
  logic              guard_bit, round_bit, sticky_bit, round_up;
  logic [SIG_W:0]    mant_rnd;
  logic signed [9:0] exp_norm, exp_final;
  logic [FRAC_W-1:0] frac_out;
  logic [15:0]       arith_val;
  logic [15:0]       result_next;

  always_comb begin
    norm       = mag << lz;
    mant       = norm[SUM_W-1 -: SIG_W];
    guard_bit  = norm[SUM_W-1-SIG_W];
    round_bit  = norm[SUM_W-2-SIG_W];
    sticky_bit = |norm[SUM_W-3-SIG_W:0];
    round_up   = guard_bit & (round_bit | sticky_bit | mant[0]);
    mant_rnd   = {1'b0, mant} + {{SIG_W{1'b0}}, round_up};

    // MSB lands on bit 28 after shifting, two places above the units bit.
    exp_norm   = big_exp + 10'sd2 - $signed({5'b0, lz});
    exp_final  = exp_norm + $signed({9'b0, mant_rnd[SIG_W]});
    frac_out   = mant_rnd[SIG_W] ? '0 : mant_rnd[FRAC_W-1:0];

    if (mag_zero) begin
      arith_val = 16'h0000;
    end else if (exp_final >= EXP_MAX) begin
      arith_val = res_sign ? NEG_INF : POS_INF;
    end else if (exp_final <= 10'sd0) begin
      arith_val = {res_sign, 15'b0};
    end else begin
      arith_val = {res_sign, exp_final[EXP_W-1:0], frac_out};
    end

    result_next = special ? special_val : arith_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= 16'h0000;
    end else begin
      out_valid <= in_valid;
      if (in_valid) result <= result_next;
    end
  end

endmodule

// File: tb/tb_bfloat16_fma.sv
// Self-checking bench for bfloat16_fma: directed vectors, randomized operands
// against an exact-integer reference model, streaming, hold and async reset.
module tb_bfloat16_fma;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] a = 16'h0;
  logic [15:0] b = 16'h0;
  logic [15:0] c = 16'h0;
  logic        out_valid;
  logic [15:0] result;

  int checks = 0;
  int failures = 0;

  bfloat16_fma dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c         (c),
    .out_valid (out_valid),
    .result    (result)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  // Reference: every finite value is scaled by 2^280 into an exact integer,
  // summed exactly, then rounded to 8 significant bits with RNE.
  function automatic logic [15:0] ref_fma(input logic [15:0] xa, input logic [15:0] xb,
                                          input logic [15:0] xc);
    int ea, eb, ec, p, sh, e;
    logic sa, sb, sc, ps, rs;
    bit za, zb, zc, ia, ib, ic, na, nb, nc;
    logic [639:0] pm, cm, mag, kept, rem, half;
    sa = xa[15]; sb = xb[15]; sc = xc[15];
    ea = int'(xa[14:7]); eb = int'(xb[14:7]); ec = int'(xc[14:7]);
    za = (ea == 0); zb = (eb == 0); zc = (ec == 0);
    ia = (ea == 255) && (xa[6:0] == 0); na = (ea == 255) && (xa[6:0] != 0);
    ib = (eb == 255) && (xb[6:0] == 0); nb = (eb == 255) && (xb[6:0] != 0);
    ic = (ec == 255) && (xc[6:0] == 0); nc = (ec == 255) && (xc[6:0] != 0);
    ps = sa ^ sb;
    if (na || nb || nc) return 16'h7FC0;
    if ((ia && zb) || (ib && za)) return 16'h7FC0;
    if (ia || ib) begin
      if (ic && (sc != ps)) return 16'h7FC0;
      return ps ? 16'hFF80 : 16'h7F80;
    end
    if (ic) return xc;
    if (za || zb) begin
      if (!zc) return xc;
      return (ps && sc) ? 16'h8000 : 16'h0000;
    end
    pm = (640'({1'b1, xa[6:0]}) * 640'({1'b1, xb[6:0]})) << (ea + eb + 12);
    cm = zc ? 640'd0 : (640'({1'b1, xc[6:0]}) << (ec + 146));
    if (ps == sc) begin
      mag = pm + cm; rs = ps;
    end else if (pm >= cm) begin
      mag = pm - cm; rs = ps;
    end else begin
      mag = cm - pm; rs = sc;
    end
    if (mag == 0) return 16'h0000;
    p = 0;
    for (int i = 0; i < 640; i++) if (mag[i]) p = i;
    sh   = p - 7;
    kept = mag >> sh;
    rem  = mag - (kept << sh);
    half = 640'd1 << (sh - 1);
    if ((rem > half) || ((rem == half) && kept[0])) kept = kept + 1;
    e = p - 280 + 127;
    if (kept == 640'd256) begin
      kept = 640'd128;
      e = e + 1;
    end
    if (e >= 255) return rs ? 16'hFF80 : 16'h7F80;
    if (e <= 0) return {rs, 15'b0};
    return {rs, 8'(e), kept[6:0]};
  endfunction

  function automatic logic [15:0] rand_op();
    int k;
    logic [15:0] v;
    k = int'($urandom_range(0, 19));
    v = 16'($urandom);
    if (k == 0) v[14:7] = 8'h00;
    else if (k == 1) v[14:0] = 15'h7F80;
    else if (k == 2) v[14:7] = 8'hFF;
    else if (k < 13) v[14:7] = 8'(96 + int'($urandom_range(0, 64)));
    return v;
  endfunction

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 16'h0000) begin
      failures++;
      $display("FAIL reset_async out_valid=%b result=%h expected 0/0000", out_valid, result);
    end
    in_valid = 1'b1; a = 16'h3F80; b = 16'h4000; c = 16'h4040;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 16'h0000) begin
      failures++;
      $display("FAIL reset_held out_valid=%b result=%h expected 0/0000", out_valid, result);
    end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release out_valid=%b expected 0", out_valid);
    end
    $display("txn reset out_valid=%b result=%h", out_valid, result);
  endtask

  task automatic test_directed();
    logic [63:0] vecs [18];
    vecs = '{64'h3F80_4000_4040_40A0, 64'hBF80_C000_4000_4080,
             64'h0000_4000_4040_4040, 64'h7F80_3F80_C040_7F80,
             64'h7FC0_3F80_4040_7FC0, 64'h7F80_0000_3F80_7FC0,
             64'h7F80_3F80_FF80_7FC0, 64'h7F7F_7F7F_0000_7F80,
             64'h0001_0001_0000_0000, 64'h0080_0100_3F80_3F80,
             64'h3F00_3E80_0001_3E00, 64'h3F81_3F81_0000_3F82,
             64'h3F80_3F80_BF80_0000, 64'h8000_3F80_8000_8000,
             64'h3F80_3F80_7F80_7F80, 64'h8080_0100_0000_8000,
             64'h3B80_3F80_3F80_3F80, 64'h3B80_3F80_3F81_3F82};
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = vecs[i][63:48]; b = vecs[i][47:32]; c = vecs[i][31:16];
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || result !== vecs[i][15:0]) begin
        failures++;
        $display("FAIL directed[%0d] out_valid=%b result=%h expected 1/%h",
                 i, out_valid, result, vecs[i][15:0]);
      end
      $display("txn directed %0d a=%h b=%h c=%h result=%h", i, a, b, c, result);
    end
    @(negedge clk) in_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] ta, tb, tc, exp_r;
    int ec;
    for (int n = 0; n < 300; n++) begin
      ta = rand_op(); tb = rand_op(); tc = rand_op();
      if ($urandom_range(0, 1) == 1) begin
        ec = int'(ta[14:7]) + int'(tb[14:7]) - 127 + int'($urandom_range(0, 4)) - 2;
        if (ec < 1) ec = 1;
        if (ec > 254) ec = 254;
        tc = {1'($urandom), 8'(ec), 7'($urandom)};
      end
      exp_r = ref_fma(ta, tb, tc);
      @(negedge clk);
      in_valid = 1'b1; a = ta; b = tb; c = tc;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || result !== exp_r) begin
        failures++;
        $display("FAIL random[%0d] a=%h b=%h c=%h out_valid=%b result=%h expected 1/%h",
                 n, ta, tb, tc, out_valid, result, exp_r);
      end
      $display("txn random %0d a=%h b=%h c=%h result=%h", n, ta, tb, tc, result);
    end
    @(negedge clk) in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] sa [5], sb [5], sc [5];
    logic [15:0] last;
    int seen;
    for (int i = 0; i < 5; i++) begin
      sa[i] = rand_op(); sb[i] = rand_op(); sc[i] = rand_op();
    end
    @(negedge clk);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_idle out_valid=%b expected 0", out_valid);
    end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = sa[i]; b = sb[i]; c = sc[i];
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
      checks++;
      if (result !== ref_fma(sa[i], sb[i], sc[i])) begin
        failures++;
        $display("FAIL stream[%0d] result=%h expected %h", i, result, ref_fma(sa[i], sb[i], sc[i]));
      end
      $display("txn stream %0d a=%h b=%h c=%h result=%h", i, sa[i], sb[i], sc[i], result);
    end
    last = ref_fma(sa[4], sb[4], sc[4]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0; a = 16'h3F80; b = 16'h3F80; c = 16'h3F80;
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
      checks++;
      if (result !== last) begin
        failures++;
        $display("FAIL hold[%0d] result=%h expected %h", i, result, last);
      end
    end
    checks++;
    if (seen != 5) begin
      failures++;
      $display("FAIL stream_valid_count out_valid_cycles=%0d expected 5", seen);
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    in_valid = 1'b1; a = 16'h3F80; b = 16'h4000; c = 16'h4040;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || result !== 16'h40A0) begin
      failures++;
      $display("FAIL midstream_pre out_valid=%b result=%h expected 1/40A0", out_valid, result);
    end
    a = 16'hBF80; b = 16'hC000; c = 16'h4000;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 16'h0000) begin
      failures++;
      $display("FAIL midstream_async out_valid=%b result=%h expected 0/0000", out_valid, result);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 16'h0000) begin
      failures++;
      $display("FAIL midstream_release out_valid=%b result=%h expected 0/0000", out_valid, result);
    end
    @(negedge clk);
    in_valid = 1'b1; a = 16'h3F00; b = 16'h3E80; c = 16'h0001;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || result !== 16'h3E00) begin
      failures++;
      $display("FAIL midstream_first out_valid=%b result=%h expected 1/3E00", out_valid, result);
    end
    $display("txn midstream a=%h b=%h c=%h result=%h", a, b, c, result);
    @(negedge clk) in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
